id_ex_fwd: RTL

ID/EX pipeline register of the RV32I five-stage pipeline. It adds load-use hazard detection and generates the 2-bit operand-forwarding selects that steer the EX-stage 32-bit 4:1 operand multiplexers. It captures decoded operands and control from ID once per cycle. On a stall or a branch flush it inserts a bubble instead, and it tells upstream stages when to hold.

---
 rtl/id_ex_fwd.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/id_ex_fwd.sv
// id_ex_fwd: RV32I ID/EX pipeline register with load-use hazard detection and EX operand forwarding selects.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   id_*                     decoded instruction fields and control from the ID stage
//   flush                    taken branch/jump in EX; the instruction entering EX is killed
//   exmem_rd/reg_write       destination of the instruction in EX/MEM
//   memwb_rd/reg_write       destination of the instruction in MEM/WB
//   ex_*                     registered EX-stage copies of the id_* fields
//   fwd_a_sel, fwd_b_sel     EX operand mux selects: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused
//   stall                    PC and IF/ID must hold this cycle (load-use hazard)
module id_ex_fwd #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_op,
    input  logic [1:0]      id_wb_sel,
    input  logic            flush,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic [3:0]      ex_alu_op,
    output logic [1:0]      ex_wb_sel,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            alu_src_q, alu_src_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [1:0]      wb_sel_q, wb_sel_d;
    logic            keep;
    logic            exm_hit_a, exm_hit_b, mwb_hit_a, mwb_hit_b;

    // A load in EX whose destination ID reads must wait one cycle; a flush
    // overrides it so upstream takes the redirect instead of holding.
    always_comb begin
        stall = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid & ~flush
              & ((id_uses_rs1 & (id_rs1 == rd_q)) | (id_uses_rs2 & (id_rs2 == rd_q)));
        // Control survives only for a real instruction that is neither flushed nor stalled.
        keep        = id_valid & ~flush & ~stall;
        valid_d     = keep;
        pc_d        = id_pc;
        rs1_data_d  = id_rs1_data;
        rs2_data_d  = id_rs2_data;
        imm_d       = id_imm;
        rs1_d       = id_rs1;
        rs2_d       = id_rs2;
        alu_src_d   = id_alu_src;
        rd_d        = keep ? id_rd : 5'd0;
        reg_write_d = keep & id_reg_write;
        mem_read_d  = keep & id_mem_read;
        mem_write_d = keep & id_mem_write;
        alu_op_d    = keep ? id_alu_op : 4'd0;
        wb_sel_d    = keep ? id_wb_sel : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= 4'd0;
            wb_sel_q    <= 2'd0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            wb_sel_q    <= wb_sel_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards
    // and a bubble in EX never selects a bypass path.
    always_comb begin
        exm_hit_a = valid_q & exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == rs1_q);
        exm_hit_b = valid_q & exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == rs2_q);
        mwb_hit_a = valid_q & memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == rs1_q);
        mwb_hit_b = valid_q & memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == rs2_q);
        fwd_a_sel = exm_hit_a ? 2'b01 : mwb_hit_a ? 2'b10 : 2'b00;
        fwd_b_sel = exm_hit_b ? 2'b01 : mwb_hit_b ? 2'b10 : 2'b00;
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_wb_sel    = wb_sel_q;
endmodule
